// File: rtl/dmem_ws.sv
// dmem_ws: word-organised data memory for the RISC-V core with a valid/ready
// request handshake, a programmable number of wait states, byte/half/word
// loads and stores, and alignment / address-range error reporting.
// Optional macro DMEM_WS_STATS_EN adds saturating load/store/error counters.
module dmem_ws #(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_WS_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_errs
`endif
);

  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);
  localparam logic [32:0] SPAN    = 33'd4 << ADDR_W;
  localparam logic [31:0] ERR_PAT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept;
  logic        enter_resp;

  // Request captured on accept
  logic        l_we;
  logic [1:0]  l_size;
  logic        l_uns;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;

  // Request being executed on the RESP-entry edge
  logic        e_we;
  logic [1:0]  e_size;
  logic        e_uns;
  logic [31:0] e_addr;
  logic [31:0] e_wdata;

  logic [31:0]       off;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] widx;
  logic              req_err;
  logic [3:0]        be;
  logic [31:0]       wr_lanes;
  logic [31:0]       rd_word;
  logic [7:0]        sel_b;
  logic [15:0]       sel_h;
  logic [31:0]       load_val;

  logic [31:0] mem [DEPTH];

  assign accept     = req_valid & req_ready;
  assign enter_resp = (state_nxt == S_RESP);

  // With zero wait states the request executes on its own accept edge,
  // so the live inputs are used while idle and the captured copy otherwise.
  assign e_we    = (state == S_IDLE) ? req_we       : l_we;
  assign e_size  = (state == S_IDLE) ? req_size     : l_size;
  assign e_uns   = (state == S_IDLE) ? req_unsigned : l_uns;
  assign e_addr  = (state == S_IDLE) ? req_addr     : l_addr;
  assign e_wdata = (state == S_IDLE) ? req_wdata    : l_wdata;

  // State register, wait counter and registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state elements use non-blocking assignments so every register
    // samples pre-edge values regardless of the order the blocks execute in.
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      req_ready <= (state_nxt == S_IDLE);
      rsp_valid <= (state_nxt == S_RESP);
    end
  end

  // Next-state and wait-counter logic
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // left one unassigned would infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          cnt_nxt   = WAIT_LD;
          state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture the request so later changes on req_* are ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l_we    <= 1'b0;
      l_size  <= 2'b00;
      l_uns   <= 1'b0;
      l_addr  <= '0;
      l_wdata <= '0;
    end else if (accept) begin
      l_we    <= req_we;
      l_size  <= req_size;
      l_uns   <= req_unsigned;
      l_addr  <= req_addr;
      l_wdata <= req_wdata;
    end
  end

  // Address decode, error detection, store lane steering and load extraction
  always_comb begin
    off      = e_addr - BASE_ADDR;
    lane     = off[1:0];
    widx     = off[ADDR_W+1:2];
    req_err  = (e_size == 2'b11)
             | ((e_size == 2'b01) & off[0])
             | ((e_size == 2'b10) & (off[1:0] != 2'b00))
             | ({1'b0, off} >= SPAN);
    be       = 4'b0000;
    wr_lanes = e_wdata;
    case (e_size)
      2'b00: begin
        be       = 4'b0001 << lane;
        wr_lanes = {4{e_wdata[7:0]}};
      end
      2'b01: begin
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{e_wdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase

    rd_word = mem[widx];
    case (lane)
      2'd0:    sel_b = rd_word[7:0];
      2'd1:    sel_b = rd_word[15:8];
      2'd2:    sel_b = rd_word[23:16];
      default: sel_b = rd_word[31:24];
    endcase
    sel_h = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (e_size)
      2'b00:   load_val = e_uns ? {24'd0, sel_b} : {{24{sel_b[7]}}, sel_b};
      2'b01:   load_val = e_uns ? {16'd0, sel_h} : {{16{sel_h[15]}}, sel_h};
      default: load_val = rd_word;
    endcase
  end

  // RAM byte-lane write on the RESP-entry edge of a legal store
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset; clearing it would turn the memory
    // into thousands of flops, and its contents are undefined at power-up.
    for (int b = 0; b < 4; b++) begin
      if (enter_resp && e_we && !req_err && be[b]) begin
        mem[widx][8*b +: 8] <= wr_lanes[8*b +: 8];
      end
    end
  end

  // Response data and error flag registered on the RESP-entry edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_err   <= req_err;
      rsp_rdata <= req_err ? ERR_PAT : (e_we ? 32'd0 : load_val);
    end
  end

`ifdef DMEM_WS_STATS_EN
  // Saturating per-class request counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errs   <= '0;
    end else if (enter_resp) begin
      if (req_err) begin
        if (stat_errs != '1) stat_errs <= stat_errs + 32'd1;
      end else if (e_we) begin
        if (stat_stores != '1) stat_stores <= stat_stores + 32'd1;
      end else begin
        if (stat_loads != '1) stat_loads <= stat_loads + 32'd1;
      end
    end
  end
`endif

endmodule
